// File: rtl/return_addr_stack.sv
// Return-address stack feeding the PC mux: CALL pushes PC_COUNT+1, RET pops with a zero-latency read.
// Define RAS_WRAP_EN to let a push while full overwrite the oldest entry instead of being dropped.
module return_addr_stack #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 32
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PUSH,
  input  logic                       POP,
  input  logic [ADDR_W-1:0]          PC_COUNT,
  input  logic                       CLR_ERR,
  output logic [ADDR_W-1:0]          RET_ADDR,
  output logic [$clog2(DEPTH):0]     COUNT,
  output logic                       EMPTY,
  output logic                       FULL,
  output logic                       OVF_ERR,
  output logic                       UNF_ERR
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem [DEPTH];

  logic [PW-1:0]     top_q, top_d;
  logic [CW-1:0]     count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;

  logic              wr_en;
  logic [PW-1:0]     wr_idx;
  logic [ADDR_W-1:0] push_val;
  logic [PW-1:0]     top_m1;
  logic              empty, full;

  assign push_val = PC_COUNT + ADDR_W'(1);
  assign top_m1   = top_q - PW'(1);
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(DEPTH));

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    wr_en   = 1'b0;
    wr_idx  = top_q;
    ovf_d   = ovf_q & ~CLR_ERR;
    unf_d   = unf_q & ~CLR_ERR;
    case ({PUSH, POP})
      2'b10: begin
        if (!full) begin
          wr_en   = 1'b1;
          top_d   = top_q + PW'(1);
          count_d = count_q + CW'(1);
        end else begin
          ovf_d = 1'b1;
`ifdef RAS_WRAP_EN
          // Circular overwrite: the slot at top is the oldest entry when full.
          wr_en = 1'b1;
          top_d = top_q + PW'(1);
`endif
        end
      end
      2'b01: begin
        if (!empty) begin
          top_d   = top_m1;
          count_d = count_q - CW'(1);
        end else begin
          unf_d = 1'b1;
        end
      end
      2'b11: begin
        if (!empty) begin
          // Return-then-call: replace the top entry in place.
          wr_en  = 1'b1;
          wr_idx = top_m1;
        end else begin
          wr_en   = 1'b1;
          top_d   = top_q + PW'(1);
          count_d = count_q + CW'(1);
          unf_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      top_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge CLK) begin
    if (wr_en) mem[wr_idx] <= push_val;
  end

  assign RET_ADDR = empty ? '0 : mem[top_m1];
  assign COUNT    = count_q;
  assign EMPTY    = empty;
  assign FULL     = full;
  assign OVF_ERR  = ovf_q;
  assign UNF_ERR  = unf_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Directed self-checking bench for return_addr_stack; honours RAS_WRAP_EN when defined.
module tb_return_addr_stack;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PUSH, POP, CLR_ERR;
    logic [9:0]  PC_COUNT;
    logic [9:0]  RET_ADDR;
    logic [5:0]  COUNT;
    logic        EMPTY, FULL, OVF_ERR, UNF_ERR;

    int n_assert = 0;
    int n_fail   = 0;
    bit done     = 1'b0;

    return_addr_stack #(.ADDR_W(10), .DEPTH(32)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .PC_COUNT(PC_COUNT),
        .CLR_ERR(CLR_ERR), .RET_ADDR(RET_ADDR), .COUNT(COUNT), .EMPTY(EMPTY),
        .FULL(FULL), .OVF_ERR(OVF_ERR), .UNF_ERR(UNF_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        if (!done) begin
            n_fail++;
            $error("FAIL timeout: test did not complete within the wait limit");
            $finish;
        end
    end

    initial begin
        RST = 1'b0; PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0; PC_COUNT = '0;
        #3;
        check("rst_count", COUNT, 6'd0);
        check("rst_empty", EMPTY, 1'b1);
        check("rst_full", FULL, 1'b0);
        check("rst_ovf", OVF_ERR, 1'b0);
        check("rst_unf", UNF_ERR, 1'b0);
        check("rst_ret", RET_ADDR, 10'h000);
        tick();
        RST = 1'b1;
        tick();

        // 1: single push / pop
        PUSH = 1'b1; PC_COUNT = 10'h010;
        tick();
        PUSH = 1'b0;
        $display("push pc=010 -> ret=%h count=%0d", RET_ADDR, COUNT);
        check("t1_ret", RET_ADDR, 10'h011);
        check("t1_count", COUNT, 6'd1);
        check("t1_empty", EMPTY, 1'b0);
        POP = 1'b1;
        #1 check("t1_ret_in_pop", RET_ADDR, 10'h011);
        tick();
        POP = 1'b0;
        $display("pop -> ret=%h count=%0d", RET_ADDR, COUNT);
        check("t1_count_after", COUNT, 6'd0);
        check("t1_ret_after", RET_ADDR, 10'h000);
        check("t1_empty_after", EMPTY, 1'b1);

        // 2: three pushes incl. address wrap, then pop order
        PUSH = 1'b1;
        PC_COUNT = 10'h100; tick();
        PC_COUNT = 10'h200; tick();
        PC_COUNT = 10'h3FF; tick();
        PUSH = 1'b0;
        $display("3 pushes -> ret=%h count=%0d", RET_ADDR, COUNT);
        check("t2_ret_wrap", RET_ADDR, 10'h000);
        check("t2_count", COUNT, 6'd3);
        POP = 1'b1;
        #1 check("t2_pop0", RET_ADDR, 10'h000);
        tick();
        check("t2_pop1", RET_ADDR, 10'h201);
        tick();
        check("t2_pop2", RET_ADDR, 10'h101);
        tick();
        POP = 1'b0;
        $display("3 pops -> count=%0d", COUNT);
        check("t2_count_end", COUNT, 6'd0);

        // 3: underflow and error clear
        POP = 1'b1; tick(); POP = 1'b0;
        $display("pop empty -> unf=%b count=%0d", UNF_ERR, COUNT);
        check("t3_unf", UNF_ERR, 1'b1);
        check("t3_count", COUNT, 6'd0);
        CLR_ERR = 1'b1; tick();
        check("t3_clr", UNF_ERR, 1'b0);
        POP = 1'b1; tick(); POP = 1'b0;
        $display("clr+pop empty -> unf=%b", UNF_ERR);
        check("t3_clr_vs_err", UNF_ERR, 1'b1);
        tick(); CLR_ERR = 1'b0;
        check("t3_clr2", UNF_ERR, 1'b0);

        // 4: fill, then push while full
        PUSH = 1'b1;
        for (int i = 0; i < 32; i++) begin
            PC_COUNT = 10'(i);
            tick();
        end
        $display("32 pushes -> full=%b count=%0d ret=%h", FULL, COUNT, RET_ADDR);
        check("t4_full", FULL, 1'b1);
        check("t4_count", COUNT, 6'd32);
        check("t4_ret", RET_ADDR, 10'h020);
        PC_COUNT = 10'h050; tick(); PUSH = 1'b0;
        $display("push while full -> ovf=%b count=%0d ret=%h", OVF_ERR, COUNT, RET_ADDR);
        check("t4_ovf", OVF_ERR, 1'b1);
        check("t4_ovf_count", COUNT, 6'd32);
        check("t4_ovf_full", FULL, 1'b1);
`ifdef RAS_WRAP_EN
        check("t4_ovf_ret", RET_ADDR, 10'h051);
        POP = 1'b1;
        #1 check("t4_wpop0", RET_ADDR, 10'h051);
        tick();
        for (int i = 1; i < 32; i++) begin
            check("t4_wpop", RET_ADDR, 10'(33 - i));
            tick();
        end
`else
        check("t4_ovf_ret", RET_ADDR, 10'h020);
        POP = 1'b1;
        for (int i = 0; i < 32; i++) begin
            #1 check("t4_pop", RET_ADDR, 10'(32 - i));
            tick();
        end
`endif
        POP = 1'b0;
        $display("32 pops -> count=%0d empty=%b", COUNT, EMPTY);
        check("t4_drained", EMPTY, 1'b1);
        CLR_ERR = 1'b1; tick(); CLR_ERR = 1'b0;
        check("t4_ovf_clr", OVF_ERR, 1'b0);

        // 5: simultaneous push+pop replaces the top
        PUSH = 1'b1;
        PC_COUNT = 10'h010; tick();
        PC_COUNT = 10'h020; tick();
        POP = 1'b1; PC_COUNT = 10'h040;
        #1 check("t5_ret_before", RET_ADDR, 10'h021);
        tick();
        PUSH = 1'b0;
        $display("push+pop pc=040 -> ret=%h count=%0d", RET_ADDR, COUNT);
        check("t5_count", COUNT, 6'd2);
        check("t5_ret", RET_ADDR, 10'h041);
        tick();
        POP = 1'b0;
        check("t5_pop", RET_ADDR, 10'h011);
        check("t5_unf", UNF_ERR, 1'b0);

        // 6: asynchronous reset mid-cycle
        PUSH = 1'b1;
        for (int i = 0; i < 4; i++) begin
            PC_COUNT = 10'(i);
            tick();
        end
        PUSH = 1'b0;
        check("t6_count_pre", COUNT, 6'd5);
        #2 RST = 1'b0;
        #1;
        $display("async reset -> count=%0d empty=%b ret=%h", COUNT, EMPTY, RET_ADDR);
        check("t6_count", COUNT, 6'd0);
        check("t6_empty", EMPTY, 1'b1);
        check("t6_ret", RET_ADDR, 10'h000);
        #1 RST = 1'b1;
        tick();
        check("t6_ovf", OVF_ERR, 1'b0);
        check("t6_unf", UNF_ERR, 1'b0);
        check("t6_count_post", COUNT, 6'd0);

        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
